// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory.
// The response struct is sized by DMEM_XLEN, so any XLEN override must match it.
package dmem_pkg;

    localparam int unsigned DMEM_XLEN        = 32;
    localparam int unsigned DMEM_DEPTH_WORDS = 1024;
    localparam int unsigned DMEM_LANES       = DMEM_XLEN / 8;
    localparam int unsigned DMEM_OFF_W       = $clog2(DMEM_LANES);
    localparam int unsigned DMEM_IDX_W       = $clog2(DMEM_DEPTH_WORDS);
    localparam int unsigned MAX_RD_LAT       = 4;
    localparam int unsigned OUT_W            = $clog2(MAX_RD_LAT + 1);

    typedef struct packed {
        logic [DMEM_XLEN-1:0] rdata;
        logic                 err;
    } dmem_rsp_t;

    // True when addr lies in [base, base + span_bytes).
    function automatic logic addr_in_range(input logic [DMEM_XLEN-1:0] addr,
                                           input logic [DMEM_XLEN-1:0] base,
                                           input logic [DMEM_XLEN:0]   span_bytes);
        logic [DMEM_XLEN:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < span_bytes);
    endfunction

endpackage

// File: rtl/data_mem_pipelined_if.sv
// Request/response bus of the pipelined data memory.
// DMEM_PARITY_EN adds the inj_parity request-side signal.
interface data_mem_pipelined_if #(
    parameter int unsigned XLEN = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN/8-1:0] req_be;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              busy;
`ifdef DMEM_PARITY_EN
    logic              inj_parity;
`endif

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
`ifdef DMEM_PARITY_EN
        output inj_parity,
`endif
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
`ifdef DMEM_PARITY_EN
        input  inj_parity,
`endif
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/dmem_rsp_fifo.sv
// Synchronous response FIFO; holds responses that arrive while the consumer stalls.
module dmem_rsp_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  dmem_rsp_t push_data,
    input  logic      pop,
    output dmem_rsp_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    dmem_rsp_t        store [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_next(wr_q);
            if (do_pop)  rd_q <= ptr_next(rd_q);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_q] <= push_data;
    end

endmodule

// File: rtl/data_mem_pipelined.sv
// Data memory with valid/ready channels, byte-lane stores and RD_LAT-cycle in-order responses.
// Define DMEM_PARITY_EN for per-byte even parity with the inj_parity fault-injection input.
module data_mem_pipelined
    import dmem_pkg::*;
#(
    parameter int unsigned     XLEN        = DMEM_XLEN,
    parameter int unsigned     DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0002_0000,
    parameter int unsigned     RD_LAT      = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_pipelined_if.slave bus
);

    localparam int unsigned        NB    = XLEN / 8;
    localparam int unsigned        OFF_W = $clog2(NB);
    localparam int unsigned        IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_XLEN:0] SPAN  = (DMEM_XLEN + 1)'(DEPTH_WORDS * NB);

    logic [XLEN-1:0]  mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic             fault, par_err;
    logic             accept, consume, rsp_valid;
    logic             push, fifo_empty, unused_fifo_full;
    logic [OUT_W-1:0] out_q, out_d;
    dmem_rsp_t        acc_rsp, push_rsp, head_rsp;

    assign idx   = bus.req_addr[OFF_W +: IDX_W];
    assign fault = !addr_in_range(bus.req_addr, BASE_ADDR, SPAN) ||
                   (bus.req_addr[OFF_W-1:0] != '0);

    // OUT never exceeds RD_LAT, so the FIFO (depth RD_LAT) cannot overflow.
    assign rsp_valid     = !fifo_empty && !reset;
    assign consume       = rsp_valid && bus.rsp_ready;
    assign bus.req_ready = !reset && ((out_q < OUT_W'(RD_LAT)) || consume);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_valid ? head_rsp.rdata : '0;
    assign bus.rsp_err   = rsp_valid && head_rsp.err;
    assign bus.busy      = !reset && (out_q != '0);

    always_comb begin
        out_d = out_q;
        if (accept && !consume)      out_d = out_q + 1'b1;
        else if (!accept && consume) out_d = out_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH_WORDS];

    always_comb begin
        par_err = 1'b0;
        for (int l = 0; l < NB; l++) begin
            par_err |= ((^mem[idx][8*l +: 8]) != par_mem[idx][l]);
        end
    end
`else
    assign par_err = 1'b0;
`endif

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !fault) begin
            for (int l = 0; l < NB; l++) begin
                if (bus.req_be[l]) begin
                    mem[idx][8*l +: 8] <= bus.req_wdata[8*l +: 8];
`ifdef DMEM_PARITY_EN
                    par_mem[idx][l] <= (^bus.req_wdata[8*l +: 8]) ^ bus.inj_parity;
`endif
                end
            end
        end
    end

    always_comb begin
        acc_rsp = '0;
        if (fault) begin
            acc_rsp.err = 1'b1;
        end else if (!bus.req_we) begin
            acc_rsp.rdata = mem[idx];
            acc_rsp.err   = par_err;
        end
    end

    // RD_LAT-1 register stages; the FIFO push edge supplies the last cycle of latency.
    if (RD_LAT > 1) begin : g_pipe
        logic      vld_q [RD_LAT-1];
        dmem_rsp_t rsp_q [RD_LAT-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < RD_LAT - 1; i++) vld_q[i] <= 1'b0;
            end else begin
                vld_q[0] <= accept;
                for (int i = 1; i < RD_LAT - 1; i++) vld_q[i] <= vld_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            rsp_q[0] <= acc_rsp;
            for (int i = 1; i < RD_LAT - 1; i++) rsp_q[i] <= rsp_q[i-1];
        end

        assign push     = vld_q[RD_LAT-2];
        assign push_rsp = rsp_q[RD_LAT-2];
    end else begin : g_nopipe
        assign push     = accept;
        assign push_rsp = acc_rsp;
    end

    dmem_rsp_fifo #(
        .DEPTH (RD_LAT)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_rsp),
        .pop       (consume),
        .head      (head_rsp),
        .full      (unused_fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_data_mem_pipelined.sv
// Scoreboard bench for data_mem_pipelined (RD_LAT=2); parity cases need DMEM_PARITY_EN.
module tb_data_mem_pipelined;
    import dmem_pkg::*;

    localparam logic [31:0] BASE = 32'h0002_0000;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    dmem_rsp_t exp_q[$];
    dmem_rsp_t mon_e;
    int        acc_cyc[$];
    int        pop_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_pipelined_if #(.XLEN(32)) bus ();

    data_mem_pipelined #(
        .XLEN        (32),
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (BASE),
        .RD_LAT      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred, none allowed", name);
    endfunction

    // Monitor: pops the scoreboard on every consumed response.
    always @(negedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                fail("stale_rsp");
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic inj = 1'b0);
        bit        done;
        dmem_rsp_t e;
        done          = 1'b0;
        e.rdata       = exp_rdata;
        e.err         = exp_err;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_wdata = wdata;
`ifdef DMEM_PARITY_EN
        bus.inj_parity = inj;
`else
        if (inj) $display("note: inj ignored without parity");
`endif
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                exp_q.push_back(e);
                acc_cyc.push_back(cyc);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) fail("accept_timeout");
`ifdef DMEM_PARITY_EN
        bus.inj_parity = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_be    = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
`ifdef DMEM_PARITY_EN
        bus.inj_parity = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Known contents for words 1..7
        for (int i = 1; i < 8; i++) issue(1'b1, BASE + 32'(4 * i), 4'hF, 32'h1000_0000 + 32'(i), 0, 0);
        idle(4);

        // Store/load with latency check
        issue(1'b1, BASE, 4'hF, 32'hDEAD_BEEF, 32'd0, 1'b0);
        idle(4);
        issue(1'b0, BASE, 4'h0, 32'd0, 32'hDEAD_BEEF, 1'b0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("lat_cycle1_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("lat_cycle2_valid", {31'd0, bus.rsp_valid}, 32'd1);
        idle(3);

        // Eight back-to-back loads
        acc_cyc.delete();
        pop_cyc.delete();
        for (int i = 0; i < 8; i++)
            issue(1'b0, BASE + 32'(4 * i), 4'h0, 32'd0,
                  (i == 0) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i), 1'b0);
        idle(6);
        chk("b2b_acc_count", acc_cyc.size(), 32'd8);
        chk("b2b_rsp_count", pop_cyc.size(), 32'd8);
        if (acc_cyc.size() == 8) chk("b2b_acc_span", acc_cyc[7] - acc_cyc[0], 32'd7);
        if (pop_cyc.size() == 8) chk("b2b_rsp_span", pop_cyc[7] - pop_cyc[0], 32'd7);

        // Byte lanes, with load right after store
        issue(1'b1, BASE + 32'd32, 4'hF, 32'h1122_3344, 32'd0, 1'b0);
        issue(1'b1, BASE + 32'd32, 4'b0010, 32'h0000_AA00, 32'd0, 1'b0);
        issue(1'b0, BASE + 32'd32, 4'h0, 32'd0, 32'h1122_AA44, 1'b0);
        idle(4);

        // Back-pressure
        bus.rsp_ready = 1'b0;
        issue(1'b0, BASE, 4'h0, 32'd0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, BASE + 32'd4, 4'h0, 32'd0, 32'h1000_0001, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_addr  = BASE + 32'd8;
        repeat (3) @(negedge clk);
        chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("stall_busy", {31'd0, bus.busy}, 32'd1);
        chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("stall_rdata_a", bus.rsp_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("stall_rdata_b", bus.rsp_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        issue(1'b0, BASE + 32'd8, 4'h0, 32'd0, 32'h1000_0002, 1'b0);
        issue(1'b0, BASE + 32'd12, 4'h0, 32'd0, 32'h1000_0003, 1'b0);
        idle(5);
        chk("drain_busy", {31'd0, bus.busy}, 32'd0);
        chk("drain_queue", exp_q.size(), 32'd0);

        // Faults
        issue(1'b0, 32'h0001_0000, 4'h0, 32'd0, 32'd0, 1'b1);
        issue(1'b0, 32'h0002_0002, 4'h0, 32'd0, 32'd0, 1'b1);
        issue(1'b1, 32'h0002_1000, 4'hF, 32'hFFFF_FFFF, 32'd0, 1'b1);
        issue(1'b1, 32'h0002_0001, 4'hF, 32'hFFFF_FFFF, 32'd0, 1'b1);
        issue(1'b1, 32'h0001_FFFC, 4'hF, 32'hFFFF_FFFF, 32'd0, 1'b1);
        issue(1'b1, 32'h0002_0FFC, 4'hF, 32'hCAFE_F00D, 32'd0, 1'b0);
        issue(1'b0, BASE, 4'h0, 32'd0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 32'h0002_0FFC, 4'h0, 32'd0, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, BASE + 32'd32, 4'h0, 32'd0, 32'h1122_AA44, 1'b0);
        issue(1'b1, BASE + 32'd36, 4'h0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        idle(4);

        // Reset with two loads in flight
        issue(1'b1, BASE + 32'd36, 4'hF, 32'h5555_AAAA, 32'd0, 1'b0);
        idle(3);
        issue(1'b0, BASE, 4'h0, 32'd0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, BASE + 32'd4, 4'h0, 32'd0, 32'h1000_0001, 1'b0);
        bus.req_valid = 1'b0;
        reset         = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        idle(5);
        issue(1'b0, BASE + 32'd36, 4'h0, 32'd0, 32'h5555_AAAA, 1'b0);
        idle(4);

`ifdef DMEM_PARITY_EN
        issue(1'b1, BASE + 32'd40, 4'hF, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
        issue(1'b0, BASE + 32'd40, 4'h0, 32'd0, 32'h1234_5678, 1'b1);
        issue(1'b1, BASE + 32'd40, 4'hF, 32'h1234_5678, 32'd0, 1'b0);
        issue(1'b0, BASE + 32'd40, 4'h0, 32'd0, 32'h1234_5678, 1'b0);
        idle(4);
`endif

        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_busy", {31'd0, bus.busy}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
